// File: rtl/noise_sampler_pkg.sv
// Shared defaults and width helpers for the noise sampler and its sample buffer.
package noise_sampler_pkg;

    localparam int DECIM_LOG2_DEF = 4;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int RND_W          = 4;

    // A sum of 2^decim_log2 values of RND_W bits never needs more than RND_W+decim_log2 bits.
    function automatic int sample_w(input int decim_log2);
        return RND_W + decim_log2;
    endfunction

endpackage

// File: rtl/noise_sampler_fifo.sv
// sample_fifo: generic circular buffer, head visible 1 cycle after push, no empty bypass.
// Push while full is accepted only when a pop happens in the same cycle; otherwise it is ignored.
module sample_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_dat,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_pop_dat,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_fill
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [FW-1:0]    r_fill;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_fill == FW'(DEPTH));
    assign o_empty   = (r_fill == '0);
    assign o_fill    = r_fill;
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    // Storage is not reset, so the head is masked while empty.
    assign o_pop_dat = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_fill <= r_fill + FW'(w_do_push) - FW'(w_do_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

endmodule

// File: rtl/noise_sampler.sv
// Noise sampler: sums RND_in over 2^DECIM_LOG2 ACLK rising edges into a FIFO; sample visible 1 cycle after push.
// Full buffer without a same-cycle pop drops the sample and sets sticky ovf; NOISE_SAMPLER_OVF_CNT_EN adds ovf_cnt.
module noise_sampler
    import noise_sampler_pkg::*;
#(
    parameter int DECIM_LOG2 = DECIM_LOG2_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                               CLK,
    input  logic                               n_RES,
    input  logic                               ACLK,
    input  logic [RND_W-1:0]                   RND_in,
    input  logic                               en,
    output logic [sample_w(DECIM_LOG2)-1:0]    s_data,
    output logic                               s_valid,
    input  logic                               s_ready,
    output logic [$clog2(FIFO_DEPTH):0]        fill,
    output logic                               ovf,
    input  logic                               clr_ovf
`ifdef NOISE_SAMPLER_OVF_CNT_EN
    ,
    output logic [7:0]                         ovf_cnt
`endif
);
    localparam int SW = sample_w(DECIM_LOG2);

    logic                  r_aclk_q;
    logic [SW-1:0]         r_acc;
    logic [DECIM_LOG2-1:0] r_cnt;
    logic                  r_ovf;
    logic                  w_tick;
    logic [SW-1:0]         w_sum;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_drop;

    // Loaded during reset too, so ACLK held high across release is not seen as an edge.
    always_ff @(posedge CLK) begin
        r_aclk_q <= ACLK;
    end

    assign w_tick = ACLK & ~r_aclk_q;
    assign w_sum  = r_acc + SW'(RND_in);
    assign w_push = n_RES & en & w_tick & (r_cnt == '1);
    assign w_pop  = s_valid & s_ready;
    assign w_drop = w_push & w_full & ~w_pop;

    always_ff @(posedge CLK) begin
        if (!n_RES || !en) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_tick) begin
            r_acc <= (r_cnt == '1) ? '0 : w_sum;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!n_RES) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    assign ovf     = r_ovf;
    assign s_valid = ~w_empty;

`ifdef NOISE_SAMPLER_OVF_CNT_EN
    logic [7:0] r_ovf_cnt;

    always_ff @(posedge CLK) begin
        if (!n_RES) begin
            r_ovf_cnt <= '0;
        end else if (clr_ovf) begin
            r_ovf_cnt <= {7'd0, w_drop};
        end else if (w_drop && r_ovf_cnt != 8'hFF) begin
            r_ovf_cnt <= r_ovf_cnt + 8'd1;
        end
    end

    assign ovf_cnt = r_ovf_cnt;
`endif

    sample_fifo #(
        .WIDTH (SW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (CLK),
        .i_rst_n    (n_RES),
        .i_push     (w_push),
        .i_push_dat (w_sum),
        .i_pop      (w_pop),
        .o_pop_dat  (s_data),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_fill     (fill)
    );

endmodule

// File: tb/tb_noise_sampler.sv
// Directed bench for noise_sampler: queue-based reference model checked every cycle plus literal expectations.
module tb_noise_sampler;
    localparam int D     = 4;
    localparam int DEPTH = 4;
    localparam int SW    = 4 + D;
    localparam int NPER  = 1 << D;

    logic                    CLK = 1'b0;
    logic                    n_RES;
    logic                    ACLK;
    logic [3:0]              RND_in;
    logic                    en;
    logic [SW-1:0]           s_data;
    logic                    s_valid;
    logic                    s_ready;
    logic [$clog2(DEPTH):0]  fill;
    logic                    ovf;
    logic                    clr_ovf;
`ifdef NOISE_SAMPLER_OVF_CNT_EN
    logic [7:0]              ovf_cnt;
`endif

    int checks = 0;
    int errors = 0;

    noise_sampler #(.DECIM_LOG2(D), .FIFO_DEPTH(DEPTH)) dut (
        .CLK     (CLK),
        .n_RES   (n_RES),
        .ACLK    (ACLK),
        .RND_in  (RND_in),
        .en      (en),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .fill    (fill),
        .ovf     (ovf),
        .clr_ovf (clr_ovf)
`ifdef NOISE_SAMPLER_OVF_CNT_EN
        ,
        .ovf_cnt (ovf_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counts ACLK rising edges, sums RND_in over each group of NPER, queues results.
    int  q[$];
    int  m_sum = 0;
    int  m_ticks = 0;
    bit  m_aclk_prev = 1'b0;
    bit  m_ovf = 1'b0;
    int  m_drops = 0;
    bit  chk_en = 1'b0;

    always @(posedge CLK) begin
        bit push, pop, full;
        int val;
        push = 1'b0;
        val  = 0;
        if (!n_RES) begin
            q.delete();
            m_sum = 0;
            m_ticks = 0;
            m_ovf = 1'b0;
            m_drops = 0;
            chk_en = 1'b1;
        end else begin
            if (!en) begin
                m_sum = 0;
                m_ticks = 0;
            end else if (ACLK && !m_aclk_prev) begin
                m_sum += int'(RND_in);
                m_ticks++;
                if (m_ticks == NPER) begin
                    push = 1'b1;
                    val = m_sum;
                    m_sum = 0;
                    m_ticks = 0;
                end
            end
            pop  = (q.size() > 0) && s_ready;
            full = (q.size() == DEPTH);
            if (push && full && !pop) begin
                m_ovf = 1'b1;
                m_drops = clr_ovf ? 1 : (m_drops < 255 ? m_drops + 1 : 255);
            end else begin
                if (clr_ovf) begin
                    m_ovf = 1'b0;
                    m_drops = 0;
                end
                if (pop) void'(q.pop_front());
                if (push) q.push_back(val);
            end
        end
        m_aclk_prev = ACLK;
        #1;
        if (chk_en) begin
            chk("s_valid", int'(s_valid), int'(q.size() != 0));
            chk("s_data", int'(s_data), (q.size() != 0) ? q[0] : 0);
            chk("fill", int'(fill), q.size());
            chk("ovf", int'(ovf), int'(m_ovf));
`ifdef NOISE_SAMPLER_OVF_CNT_EN
            chk("ovf_cnt", int'(ovf_cnt), m_drops);
`endif
        end
    end

    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) begin
            ACLK = 1'b1;
            @(negedge CLK);
            ACLK = 1'b0;
            @(negedge CLK);
        end
    endtask

    task automatic drain(input int n);
        s_ready = 1'b1;
        repeat (n) @(negedge CLK);
        s_ready = 1'b0;
    endtask

    initial begin
        n_RES = 1'b0; ACLK = 1'b0; RND_in = 4'h0; en = 1'b0; s_ready = 1'b0; clr_ovf = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_fill", int'(fill), 0);
        chk("rst_valid", int'(s_valid), 0);
        chk("rst_data", int'(s_data), 0);
        n_RES = 1'b1;
        @(negedge CLK);

        // Constant 0xA over 16 ticks gives 0xA0.
        en = 1'b1; RND_in = 4'hA;
        pulse(15);
        chk("a0_before", int'(s_valid), 0);
        pulse(1);
        chk("a0_valid", int'(s_valid), 1);
        chk("a0_data", int'(s_data), 8'hA0);
        drain(1);
        chk("a0_drained", int'(fill), 0);

        // Five sample periods with no consumer: fifth sample dropped.
        RND_in = 4'hF;
        pulse(5 * NPER);
        chk("full_fill", int'(fill), 4);
        chk("full_ovf", int'(ovf), 1);
        chk("full_head", int'(s_data), 8'hF0);
`ifdef NOISE_SAMPLER_OVF_CNT_EN
        chk("full_ovf_cnt", int'(ovf_cnt), 1);
`endif
        clr_ovf = 1'b1;
        @(negedge CLK);
        clr_ovf = 1'b0;
        chk("ovf_cleared", int'(ovf), 0);

        // Push while full with a same-cycle pop.
        pulse(NPER - 1);
        s_ready = 1'b1; ACLK = 1'b1;
        @(negedge CLK);
        s_ready = 1'b0; ACLK = 1'b0;
        @(negedge CLK);
        chk("pp_fill", int'(fill), 4);
        chk("pp_ovf", int'(ovf), 0);
        for (int i = 0; i < 4; i++) begin
            chk("pp_entry", int'(s_data), 8'hF0);
            drain(1);
        end
        chk("pp_empty", int'(fill), 0);

        // Drop coinciding with clr_ovf keeps ovf set.
        RND_in = 4'h1;
        pulse(4 * NPER + NPER - 1);
        ACLK = 1'b1; clr_ovf = 1'b1;
        @(negedge CLK);
        ACLK = 1'b0; clr_ovf = 1'b0;
        chk("clr_drop_ovf", int'(ovf), 1);
`ifdef NOISE_SAMPLER_OVF_CNT_EN
        chk("clr_drop_cnt", int'(ovf_cnt), 1);
`endif
        @(negedge CLK);
        clr_ovf = 1'b1;
        @(negedge CLK);
        clr_ovf = 1'b0;
        chk("clr_alone_ovf", int'(ovf), 0);
        chk("clr_head", int'(s_data), 8'h10);
        drain(4);

        // Dropping en discards the partial sum.
        RND_in = 4'hA;
        pulse(7);
        en = 1'b0;
        repeat (2) @(negedge CLK);
        en = 1'b1; RND_in = 4'h1;
        pulse(NPER);
        chk("en_fill", int'(fill), 1);
        chk("en_data", int'(s_data), 8'h10);
        drain(1);

        // Reset mid-accumulation with ACLK high across release.
        RND_in = 4'h3;
        pulse(5);
        ACLK = 1'b1; n_RES = 1'b0;
        repeat (2) @(negedge CLK);
        n_RES = 1'b1;
        repeat (2) @(negedge CLK);
        ACLK = 1'b0;
        @(negedge CLK);
        pulse(NPER - 1);
        chk("rel_no_tick", int'(fill), 0);
        pulse(1);
        chk("rel_fill", int'(fill), 1);
        chk("rel_data", int'(s_data), 8'h30);
        drain(1);
        repeat (2) @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/noise_sampler.md
NOISE_SAMPLER -- requirements
Module: noise_sampler

Interface
REQ-001 SHALL have parameter DECIM_LOG2, default 4, log2 of ACLK ticks summed per output sample (legal 1..6).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, sample buffer depth (power of two, 2..16).
REQ-003 SHALL have port CLK  input  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port n_RES  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port ACLK  input  1  APU ACLK level, sampled in the CLK domain.
REQ-006 SHALL have port RND_in  input  4  noise channel output, consumed downstream of NoiseChan RND_out.
REQ-007 SHALL have port en  input  1  capture enable.
REQ-008 SHALL have port s_data  output  4+DECIM_LOG2  head-of-buffer sample.
REQ-009 SHALL have port s_valid  output  1  buffer non-empty.
REQ-010 SHALL have port s_ready  input  1  consumer accepts s_data.
REQ-011 SHALL have port fill  output  clog2(FIFO_DEPTH)+1  current buffer occupancy.
REQ-012 SHALL have port ovf  output  1  sticky dropped-sample flag.
REQ-013 SHALL have port clr_ovf  input  1  clears ovf.

Function
REQ-014 SHALL register ACLK into aclk_q each cycle; tick = ACLK & ~aclk_q (one CLK cycle per ACLK rising edge).
REQ-015 On tick with en=1: acc <= acc + RND_in, cnt <= cnt + 1 (cnt DECIM_LOG2 bits, wraps).
REQ-016 On tick with en=1 and cnt = 2^DECIM_LOG2-1: push acc+RND_in into the buffer, acc <= 0, cnt <= 0.
REQ-017 Sum SHALL be unsigned, width 4+DECIM_LOG2, never overflow (max 15*2^DECIM_LOG2).
REQ-018 en=0 SHALL clear acc and cnt every cycle; buffered samples remain poppable.
REQ-019 s_valid = (fill != 0); s_data = oldest entry; pop occurs when s_valid & s_ready.
REQ-020 Pushed sample SHALL appear on s_data/s_valid the cycle after the push edge (latency 1).
REQ-021 Push when full without same-cycle pop: sample dropped, contents unchanged, ovf <= 1.
REQ-022 Push and pop same cycle when full: both performed, fill unchanged, no ovf.
REQ-023 Push and pop same cycle when empty: push only (no bypass), fill becomes 1.
REQ-024 clr_ovf and a drop in the same cycle: ovf SHALL remain 1 (set wins).
REQ-025 Read/write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-026 n_RES=0 at a CLK edge: acc=0, cnt=0, pointers=0, fill=0, s_valid=0, ovf=0, s_data=0.
REQ-027 During reset aclk_q SHALL load ACLK so no spurious tick occurs on the first cycle after release.
REQ-028 Reset asserted mid-accumulation SHALL discard the partial sum.

Configuration
REQ-029 Macro NOISE_SAMPLER_OVF_CNT_EN defined: extra output ovf_cnt (8 bits) counting dropped samples, saturating at 255, cleared by clr_ovf (drop in same cycle yields 1) and by reset.
REQ-030 Macro undefined: no ovf_cnt port or counter logic; all other behaviour identical.

Structure
REQ-031 Package noise_sampler_pkg SHALL hold defaults for DECIM_LOG2/FIFO_DEPTH, RND width constant (4) and sample-width function.
REQ-032 Buffer SHALL be sub-module sample_fifo (parameterised width/depth, push/pop/full/empty/fill).
REQ-033 Edge detect, accumulator and overflow logic SHALL live in noise_sampler.

Verification
REQ-034 RND_in=4'hA constant, en=1, 16 ticks -> one sample s_data=8'hA0, s_valid rises 1 cycle after 16th tick edge.
REQ-035 RND_in=4'hF, s_ready=0, 5 sample periods -> fill=4, ovf=1 after 5th push, 4 entries all 8'hF0; ovf_cnt=1 when macro defined.
REQ-036 Buffer full, s_ready=1 held during push cycle -> fill stays 4, ovf stays 0.
REQ-037 en dropped after 7 ticks, re-raised, 16 more ticks with RND_in=4'h1 -> single sample 8'h10.
REQ-038 ACLK held high through reset release -> no tick on first cycle; first sample after 16 real rising edges.
REQ-039 clr_ovf pulsed same cycle as a drop -> ovf=1; pulsed alone next cycle -> ovf=0.
